fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel plus the IF/ID register outputs
// that feed the decode stage.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;

  // Fetch-unit side
  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    output id_valid, id_instr, id_pc, id_pc4, id_opcode, id_funct3, id_funct7
  );

  // Memory / decoder side
  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    input  id_valid, id_instr, id_pc, id_pc4, id_opcode, id_funct3, id_funct7
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, back-to-back
// issue on response, a one-entry hold buffer for responses that arrive while
// decode is stalled, and redirect handling that drains stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  output logic         misalign_err,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic [31:0] hold_instr_q;
  logic [31:0] hold_pc_q;
  logic        id_valid_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;
  logic        misalign_q;

  logic        accept_d;
  logic        issue_d;
  logic [31:0] pc_inc_d;
  logic [31:0] redirect_tgt_d;

  // Request issue is combinational so a response can trigger the next request
  // in the same cycle; redirect and reset suppress it.
  always_comb begin
    accept_d       = !stall_i || !id_valid_q;
    pc_inc_d       = pc_q + 32'd4;
    redirect_tgt_d = {redirect_pc_i[31:2], 2'b00};
    issue_d        = 1'b0;
    if (!rst && !redirect_i) begin
      case (state_q)
        ST_FETCH: issue_d = 1'b1;
        ST_WAIT:  issue_d = bus.imem_rvalid && accept_d;
        default:  issue_d = 1'b0;
      endcase
    end
  end

  // FSM, PC, hold buffer and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      id_pc_q      <= '0;
      misalign_q   <= 1'b0;
    end else begin
      misalign_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);

      if (issue_d) begin
        req_addr_q <= pc_q;
        pc_q       <= pc_inc_d;
      end

      if (redirect_i) begin
        pc_q       <= redirect_tgt_d;
        id_valid_q <= 1'b0;
        id_instr_q <= NOP_INSTR;
        case (state_q)
          ST_WAIT:  state_q <= bus.imem_rvalid ? ST_FETCH : ST_DRAIN;
          // A response landing together with a redirect in DRAIN is the one
          // being drained, so nothing remains outstanding.
          ST_DRAIN: state_q <= bus.imem_rvalid ? ST_FETCH : ST_DRAIN;
          default:  state_q <= ST_FETCH;
        endcase
      end else begin
        // Bubble by default when decode can take a new word; loads below win.
        if (accept_d) begin
          id_valid_q <= 1'b0;
          id_instr_q <= NOP_INSTR;
        end
        case (state_q)
          ST_FETCH: state_q <= ST_WAIT;
          ST_WAIT: begin
            if (bus.imem_rvalid) begin
              if (accept_d) begin
                id_valid_q <= 1'b1;
                id_instr_q <= bus.imem_rdata;
                id_pc_q    <= req_addr_q;
              end else begin
                hold_instr_q <= bus.imem_rdata;
                hold_pc_q    <= req_addr_q;
                state_q      <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (accept_d) begin
              id_valid_q <= 1'b1;
              id_instr_q <= hold_instr_q;
              id_pc_q    <= hold_pc_q;
              state_q    <= ST_FETCH;
            end
          end
          ST_DRAIN: begin
            if (bus.imem_rvalid) state_q <= ST_FETCH;
          end
          default: state_q <= ST_FETCH;
        endcase
      end
    end
  end

  assign bus.imem_req  = issue_d;
  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_pc4    = id_pc_q + 32'd4;
  assign bus.id_opcode = id_instr_q[6:0];
  assign bus.id_funct3 = id_instr_q[14:12];
  assign bus.id_funct7 = id_instr_q[31:25];
  assign misalign_err  = misalign_q;

endmodule
